// File: rtl/spi_reg_ctrl.sv
// SPI-to-register bridge: decodes a command byte, then streams writes or reads with auto-increment.
// Latency: reg_we 1 edge after a data strobe; tx_valid 2 edges after entering RD_ISSUE. Backpressure: tx_byte held until tx_ready.
module spi_reg_ctrl #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic [DATA_BITS-1:0] rx_byte,
  input  logic                 rx_strobe,
  output logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [DATA_BITS-1:0] reg_rdata,
  output logic                 busy,
  output logic                 err_underrun
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RD_ISSUE,
    RD_CAPTURE,
    RDATA
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] tx_byte_nxt;
  logic                 tx_valid_nxt;
  logic [ADDR_BITS-1:0] reg_addr_nxt;
  logic [DATA_BITS-1:0] reg_wdata_nxt;
  logic                 reg_we_nxt;
  logic                 reg_re_nxt;
  logic                 busy_nxt;
  logic                 err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tx_byte      <= '0;
      tx_valid     <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx_byte      <= tx_byte_nxt;
      tx_valid     <= tx_valid_nxt;
      reg_addr     <= reg_addr_nxt;
      reg_wdata    <= reg_wdata_nxt;
      reg_we       <= reg_we_nxt;
      reg_re       <= reg_re_nxt;
      busy         <= busy_nxt;
      err_underrun <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_byte_nxt   = tx_byte;
    tx_valid_nxt  = tx_valid;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    err_nxt       = err_underrun;

    if (cs) begin
      // Deselect beats any strobe on the same edge; the address is kept.
      state_nxt    = IDLE;
      tx_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = CMD;
          err_nxt   = 1'b0;
        end
        CMD: begin
          if (rx_strobe) begin
            reg_addr_nxt = rx_byte[ADDR_BITS-1:0];
            if (rx_byte[DATA_BITS-1]) begin
              state_nxt  = RD_ISSUE;
              reg_re_nxt = 1'b1;
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        WDATA: begin
          if (reg_we) reg_addr_nxt = reg_addr + 1'b1;
          if (rx_strobe) begin
            reg_we_nxt    = 1'b1;
            reg_wdata_nxt = rx_byte;
          end
        end
        RD_ISSUE: begin
          if (tx_ready && !tx_valid) err_nxt = 1'b1;
          state_nxt = RD_CAPTURE;
        end
        RD_CAPTURE: begin
          if (tx_ready && !tx_valid) err_nxt = 1'b1;
          tx_byte_nxt  = reg_rdata;
          tx_valid_nxt = 1'b1;
          state_nxt    = RDATA;
        end
        RDATA: begin
          // Handshake re-enters RD_ISSUE with the read already launched for the next address.
          if (tx_valid && tx_ready) begin
            tx_valid_nxt = 1'b0;
            reg_addr_nxt = reg_addr + 1'b1;
            reg_re_nxt   = 1'b1;
            state_nxt    = RD_ISSUE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a one-cycle-latency register file model.
module tb_spi_reg_ctrl;
  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       reset = 1'b1;
  logic       cs = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_strobe = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       err_underrun;

  logic [7:0] mem [0:127];
  int         n_checks = 0;
  int         n_fail = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         both_cnt = 0;
  int         we_snap;
  int         re_snap;

  spi_reg_ctrl dut (
    .clk(clk), .reset(reset), .cs(cs), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err_underrun(err_underrun)
  );

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) we_cnt++;
    if (reg_re) re_cnt++;
    if (reg_we && reg_re) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[3] = 8'h3C;
    mem[4] = 8'hC3;
    mem[1] = 8'h5A;

    #1;
    check("rst_busy", busy, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_addr", reg_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Single write
    cs = 1'b0;
    tick();
    check("cmd_busy", busy, 1);
    we_snap = we_cnt;
    re_snap = re_cnt;
    send(8'h05);
    check("wr_no_we_cmd", reg_we, 0);
    send(8'hA5);
    check("wr_we", reg_we, 1);
    check("wr_addr", reg_addr, 8'h05);
    check("wr_wdata", reg_wdata, 8'hA5);
    tick();
    check("wr_we_pulse", reg_we, 0);
    check("wr_addr_inc", reg_addr, 8'h06);
    check("wr_we_cnt", we_cnt - we_snap, 1);
    check("wr_no_re", re_cnt - re_snap, 0);
    cs = 1'b1;
    tick();
    check("wr_end_busy", busy, 0);

    // Burst write across the address wrap
    cs = 1'b0;
    tick();
    send(8'h7F);
    send(8'h11);
    check("wrap_we0", reg_we, 1);
    check("wrap_addr0", reg_addr, 8'h7F);
    check("wrap_wdata0", reg_wdata, 8'h11);
    tick();
    check("wrap_addr_inc", reg_addr, 8'h00);
    send(8'h22);
    check("wrap_we1", reg_we, 1);
    check("wrap_addr1", reg_addr, 8'h00);
    check("wrap_wdata1", reg_wdata, 8'h22);
    cs = 1'b1;
    tick();

    // Burst read from address 3
    cs = 1'b0;
    tick();
    we_snap = we_cnt;
    send(8'h83);
    check("rd_re", reg_re, 1);
    check("rd_addr", reg_addr, 8'h03);
    check("rd_txv_e1", tx_valid, 0);
    tick();
    check("rd_re_pulse", reg_re, 0);
    check("rd_txv_e2", tx_valid, 0);
    tick();
    check("rd_txv_e3", tx_valid, 1);
    check("rd_byte0", tx_byte, 8'h3C);
    send(8'hFF);
    check("rd_hold", tx_byte, 8'h3C);
    check("rd_hold_v", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("rd_hs_txv", tx_valid, 0);
    check("rd_hs_addr", reg_addr, 8'h04);
    check("rd_hs_re", reg_re, 1);
    tick();
    check("rd_hs_e2", tx_valid, 0);
    tick();
    check("rd_byte1_v", tx_valid, 1);
    check("rd_byte1", tx_byte, 8'hC3);
    check("rd_dummy_no_we", we_cnt - we_snap, 0);
    check("rd_err_clear", err_underrun, 0);

    // Async reset pulse with the clock stopped in RDATA
    clk_en = 1'b0;
    #20;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("ar_txv", tx_valid, 0);
    check("ar_txbyte", tx_byte, 0);
    check("ar_addr", reg_addr, 0);
    check("ar_wdata", reg_wdata, 0);
    check("ar_busy", busy, 0);
    check("ar_re", reg_re, 0);
    cs = 1'b1;
    clk_en = 1'b1;
    tick();
    tick();

    // Underrun during RD_ISSUE
    cs = 1'b0;
    tick();
    send(8'h81);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("ur_set", err_underrun, 1);
    tick();
    tick();
    check("ur_txv", tx_valid, 1);
    check("ur_byte", tx_byte, 8'h5A);
    check("ur_hold", err_underrun, 1);
    cs = 1'b1;
    tick();
    check("ur_cs_hi_hold", err_underrun, 1);
    check("ur_cs_txv", tx_valid, 0);
    cs = 1'b0;
    tick();
    check("ur_clear", err_underrun, 0);
    cs = 1'b1;
    tick();

    // Abort colliding with a data strobe
    cs = 1'b0;
    tick();
    send(8'h10);
    we_snap = we_cnt;
    rx_byte   = 8'h55;
    rx_strobe = 1'b1;
    cs        = 1'b1;
    tick();
    rx_strobe = 1'b0;
    check("ab_no_we", reg_we, 0);
    check("ab_busy", busy, 0);
    check("ab_addr", reg_addr, 8'h10);
    tick();
    check("ab_we_cnt", we_cnt - we_snap, 0);

    // Reset mid-frame, then a fresh command
    cs = 1'b0;
    tick();
    send(8'h20);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("mf_busy", busy, 0);
    tick();
    send(8'h12);
    check("mf_cmd_no_we", reg_we, 0);
    send(8'h34);
    check("mf_we", reg_we, 1);
    check("mf_addr", reg_addr, 8'h12);
    check("mf_wdata", reg_wdata, 8'h34);
    cs = 1'b1;
    tick();

    check("we_re_excl", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 7, register address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, byte width; it matches the SPI slave buffer widths.
REQ-003 The block SHALL have port clk  input  1  the SPI clock, which is the single clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port cs  input  1  chip select, active low; high means the frame is aborted or ended.
REQ-006 The block SHALL have port rx_byte  input  DATA_BITS  received byte, taken from the slave out_buffer.
REQ-007 The block SHALL have port rx_strobe  input  1  single-cycle flag meaning rx_byte is valid.
REQ-008 The block SHALL have port tx_byte  output  DATA_BITS  byte to transmit, driven to the slave in_buffer.
REQ-009 The block SHALL have port tx_valid  output  1  tx_byte is valid.
REQ-010 The block SHALL have port tx_ready  input  1  the slave can accept tx_byte.
REQ-011 The block SHALL have port reg_addr  output  ADDR_BITS  register file address.
REQ-012 The block SHALL have port reg_wdata  output  DATA_BITS  register write data.
REQ-013 The block SHALL have port reg_we  output  1  single-cycle write enable.
REQ-014 The block SHALL have port reg_re  output  1  single-cycle read enable; reg_rdata becomes valid 1 cycle later.
REQ-015 The block SHALL have port reg_rdata  input  DATA_BITS  register read data.
REQ-016 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 The block SHALL have port err_underrun  output  1  sticky flag meaning tx_ready was seen while no read data was valid.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, CMD, WDATA, RD_ISSUE, RD_CAPTURE, RDATA; all outputs are registered.
REQ-019 Leaving IDLE: from IDLE with cs=0, the FSM SHALL go to CMD on the next edge and clear err_underrun.
REQ-020 Command decode: in CMD, on rx_strobe the block SHALL latch rw=rx_byte[7] and reg_addr=rx_byte[ADDR_BITS-1:0].
REQ-021 Write command: after the command byte, rw=0 SHALL select WDATA.
REQ-022 Read command: after the command byte, rw=1 SHALL select RD_ISSUE.
REQ-023 Write data: in WDATA, each rx_strobe SHALL assert reg_we for exactly 1 cycle with reg_wdata=rx_byte and the current reg_addr.
REQ-024 Write auto-increment: after the reg_we cycle, reg_addr SHALL increment by 1, wrapping from 2^ADDR_BITS-1 to 0.
REQ-025 Read issue: RD_ISSUE SHALL assert reg_re for exactly 1 cycle and then go to RD_CAPTURE.
REQ-026 Read capture: RD_CAPTURE SHALL load tx_byte=reg_rdata, set tx_valid=1, and go to RDATA.
REQ-027 Read handshake: in RDATA, when tx_valid and tx_ready are both high, the block SHALL complete the transfer, clear tx_valid, increment reg_addr with wrap, and go to RD_ISSUE.
REQ-028 Read latency: tx_valid SHALL rise 3 clk edges after the command rx_strobe, and 3 edges after each handshake.
REQ-029 Read-side receive: in RD_ISSUE, RD_CAPTURE and RDATA, rx_strobe SHALL be ignored, since bytes clocked in during a read are dummy bytes.
REQ-030 Underrun: tx_ready=1 with tx_valid=0 while in RD_ISSUE or RD_CAPTURE SHALL set err_underrun, which then holds until the next IDLE to CMD transition.
REQ-031 Abort: cs=1 at any edge SHALL force IDLE, clear tx_valid, reg_we and reg_re, and leave reg_addr unchanged.
REQ-032 Abort priority: when cs=1 and rx_strobe arrive on the same edge, cs SHALL win and no reg_we is issued.
REQ-033 tx_byte hold: tx_byte SHALL hold its value while tx_valid=1 and tx_ready=0.
REQ-034 Mutual exclusion: reg_we and reg_re SHALL never be high in the same cycle.

Reset
REQ-035 Asserting reset SHALL immediately force IDLE, set tx_byte=0, tx_valid=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0 and err_underrun=0, with no clock required.
REQ-036 Reset asserted mid-frame SHALL discard the frame; after release with cs=0, the next rx_strobe SHALL be decoded as a command.

Verification
REQ-037 Single write: cs=0, rx bytes 0x05 then 0xA5 -> one reg_we pulse with addr=0x05 and wdata=0xA5; no reg_re.
REQ-038 Burst write with wrap: rx bytes 0x7F, 0x11, 0x22 -> reg_we at addr 0x7F with 0x11, then at addr 0x00 with 0x22.
REQ-039 Burst read: rx byte 0x83, reg file holds 0x3C@3 and 0xC3@4 -> reg_re at 3 one cycle after the strobe; tx_byte=0x3C with tx_valid 3 edges after the strobe; after the handshake, tx_byte=0xC3.
REQ-040 Abort: cs=1 on the same edge as the rx_strobe of data byte 0x55 in WDATA -> no reg_we, state returns to IDLE, busy=0.
REQ-041 Underrun: read command followed by tx_ready=1 the next cycle -> err_underrun=1, which holds until cs toggles 1 then 0.
REQ-042 Async reset: reset pulse of 1 ns with the clock stopped while in RDATA -> all outputs read zero before any clk edge.
